// File: rtl/lane_block_sync.sv
// Per-lane 64B/66B block synchroniser: barrel-shifts the raw SerDes words onto
// 66-bit block boundaries and runs the sync-header block-lock state machine.
module lane_block_sync #(
  parameter int SH_CNT_MAX     = 64,
  parameter int SH_INVALID_MAX = 16
) (
  input  logic        lane_clk,
  input  logic        reset,
  input  logic [65:0] raw_data,
  output logic [65:0] block_out,
  output logic        block_valid,
  output logic        block_lock,
  output logic        slip,
  output logic [6:0]  offset
);

  localparam logic [6:0] CNT_MAX = 7'(SH_CNT_MAX);
  localparam logic [4:0] INV_MAX = 5'(SH_INVALID_MAX);

  typedef enum logic [1:0] {LOCK_INIT, TEST_SH, SLIP} state_t;

  state_t       state;
  logic [65:0]  prev_word;
  logic [131:0] window;
  logic [7:0]   sel_base;
  logic [65:0]  slice;
  logic         hold;
  logic [6:0]   sh_cnt;
  logic [4:0]   sh_invalid_cnt;
  logic         sh_ok;
  logic         test_now;
  logic [6:0]   cnt_inc;
  logic [4:0]   inv_inc;

  // The header is judged on the block being registered this edge, so the
  // tested block and its valid flag appear on block_out together.
  assign window   = {raw_data, prev_word};
  assign sel_base = {1'b0, offset};
  assign slice    = window[sel_base +: 66];
  assign sh_ok    = slice[0] ^ slice[1];
  assign test_now = (state == TEST_SH) && !hold;
  assign cnt_inc  = sh_cnt + 7'd1;
  assign inv_inc  = sh_invalid_cnt + {4'd0, ~sh_ok};

  always_ff @(posedge lane_clk or posedge reset) begin
    if (reset) begin
      prev_word   <= '0;
      block_out   <= '0;
      block_valid <= 1'b0;
    end else begin
      prev_word   <= raw_data;
      block_out   <= slice;
      block_valid <= test_now;
    end
  end

  always_ff @(posedge lane_clk or posedge reset) begin
    if (reset) begin
      state          <= LOCK_INIT;
      hold           <= 1'b1;
      block_lock     <= 1'b0;
      slip           <= 1'b0;
      offset         <= '0;
      sh_cnt         <= '0;
      sh_invalid_cnt <= '0;
    end else begin
      slip <= 1'b0;
      hold <= 1'b0;
      case (state)
        LOCK_INIT: begin
          sh_cnt         <= '0;
          sh_invalid_cnt <= '0;
          state          <= TEST_SH;
        end
        TEST_SH: begin
          if (!hold) begin
            if (block_lock) begin
              // Loss of lock is checked first so it beats the window clear.
              if (inv_inc == INV_MAX) begin
                block_lock     <= 1'b0;
                sh_cnt         <= '0;
                sh_invalid_cnt <= '0;
                state          <= SLIP;
              end else if (cnt_inc == CNT_MAX) begin
                sh_cnt         <= '0;
                sh_invalid_cnt <= '0;
              end else begin
                sh_cnt         <= cnt_inc;
                sh_invalid_cnt <= inv_inc;
              end
            end else if (!sh_ok) begin
              state <= SLIP;
            end else if (cnt_inc == CNT_MAX) begin
              block_lock     <= 1'b1;
              sh_cnt         <= '0;
              sh_invalid_cnt <= '0;
            end else begin
              sh_cnt <= cnt_inc;
            end
          end
        end
        SLIP: begin
          offset         <= (offset == 7'd65) ? 7'd0 : offset + 7'd1;
          slip           <= 1'b1;
          hold           <= 1'b1;
          sh_cnt         <= '0;
          sh_invalid_cnt <= '0;
          state          <= TEST_SH;
        end
        default: state <= LOCK_INIT;
      endcase
    end
  end

endmodule

// File: tb/tb_lane_block_sync.sv
// Bench for lane_block_sync: builds a serial 64B/66B stream with a chosen bit
// delay, slices it into raw words, and checks lock/slip/alignment behaviour.
module tb_lane_block_sync;

  logic        lane_clk = 1'b0;
  logic        reset    = 1'b1;
  logic [65:0] raw_data = '0;
  logic [65:0] block_out;
  logic        block_valid;
  logic        block_lock;
  logic        slip;
  logic [6:0]  offset;

  int errors = 0;
  int checks = 0;

  logic [65:0] tx_blk [4096];
  logic [65:0] junk;
  int delay;
  int k;
  int slips, max_off, last_slip_edge, lock_edge;

  lane_block_sync dut (
    .lane_clk   (lane_clk),
    .reset      (reset),
    .raw_data   (raw_data),
    .block_out  (block_out),
    .block_valid(block_valid),
    .block_lock (block_lock),
    .slip       (slip),
    .offset     (offset)
  );

  always #5 lane_clk = ~lane_clk;

  task automatic checkOutput(input string tag, input logic [65:0] obs, input logic [65:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Serial line model: 'delay' junk bits, then the transmitted blocks back to back.
  function automatic logic stream_bit(input int i);
    int j;
    if (i < delay) return junk[7'(i)];
    j = i - delay;
    return tx_blk[12'(j / 66)][7'(j % 66)];
  endfunction

  function automatic logic [1:0] bad_hdr();
    return ($urandom_range(1, 0) == 1) ? 2'b11 : 2'b00;
  endfunction

  task automatic applyStimulus();
    logic [65:0] w;
    for (int b = 0; b < 66; b++) w[7'(b)] = stream_bit(66 * k + b);
    raw_data = w;
  endtask

  task automatic step();
    @(posedge lane_clk);
    #1;
    k++;
    applyStimulus();
  endtask

  task automatic gen_stream(input int d, input bit zero_payload);
    delay = d;
    junk  = {2'($urandom), $urandom, $urandom};
    foreach (tx_blk[i]) begin
      if (zero_payload) tx_blk[i] = 66'h1;
      else tx_blk[i] = {$urandom, $urandom, ($urandom_range(1, 0) == 1) ? 2'b01 : 2'b10};
    end
  endtask

  task automatic mark_invalid(input int lo, input int span, input int n, output int last);
    bit used [64];
    int cnt;
    int p;
    foreach (used[i]) used[i] = 1'b0;
    cnt  = 0;
    last = lo;
    while (cnt < n) begin
      p = int'($urandom_range(span - 1, 0));
      if (!used[p]) begin
        used[p] = 1'b1;
        cnt++;
        tx_blk[12'(lo + p)][1:0] = bad_hdr();
        if (lo + p > last) last = lo + p;
      end
    end
  endtask

  task automatic start_run();
    reset = 1'b1;
    repeat (2) @(posedge lane_clk);
    #1;
    reset = 1'b0;
    k = 0;
    applyStimulus();
  endtask

  task automatic run_to_lock(input int max_cycles, input string tag);
    bit got;
    got = 1'b0;
    slips = 0;
    max_off = 0;
    last_slip_edge = 0;
    lock_edge = 0;
    for (int c = 0; c < max_cycles && !got; c++) begin
      step();
      if (slip) begin
        slips++;
        last_slip_edge = k;
      end
      if (int'(offset) > max_off) max_off = int'(offset);
      if (block_lock) begin
        got = 1'b1;
        lock_edge = k;
      end
    end
    checkOutput({tag, "_lock_reached"}, 66'(got), 66'd1);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation still running at time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int bad;
    int last_w3;
    int dummy;

    // Aligned stream, header 01 and zero payload.
    gen_stream(0, 1'b1);
    start_run();
    checkOutput("t2_c0_valid", 66'(block_valid), 66'd0);
    checkOutput("t2_c0_lock", 66'(block_lock), 66'd0);
    checkOutput("t2_c0_block", block_out, 66'd0);
    checkOutput("t2_c0_offset", 66'(offset), 66'd0);
    step();
    checkOutput("t2_hold_valid", 66'(block_valid), 66'd0);
    step();
    checkOutput("t2_first_valid", 66'(block_valid), 66'd1);
    checkOutput("t2_first_block", block_out, tx_blk[0]);
    bad = 0;
    while (k < 64) begin
      step();
      if (slip || block_lock) bad++;
    end
    checkOutput("t2_pre_lock_quiet", 66'(bad), 66'd0);
    step();
    checkOutput("t2_lock_at_65", 66'(block_lock), 66'd1);
    checkOutput("t2_offset", 66'(offset), 66'd0);
    checkOutput("t2_block_65", block_out, tx_blk[63]);

    // Stream delayed by 17 bits with random payloads.
    gen_stream(17, 1'b0);
    start_run();
    run_to_lock(3000, "t3");
    checkOutput("t3_slips", 66'(slips), 66'd17);
    checkOutput("t3_offset", 66'(offset), 66'd17);
    checkOutput("t3_lock_edge", 66'(lock_edge), 66'(last_slip_edge + 65));
    for (int i = 0; i < 8; i++) begin
      step();
      checkOutput("t3_valid", 66'(block_valid), 66'd1);
      checkOutput("t3_block", block_out, tx_blk[12'(k - 2)]);
    end

    // Asynchronous reset while locked, checked between clock edges.
    checkOutput("t1_pre_lock", 66'(block_lock), 66'd1);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("t1_block", block_out, 66'd0);
    checkOutput("t1_valid", 66'(block_valid), 66'd0);
    checkOutput("t1_lock", 66'(block_lock), 66'd0);
    checkOutput("t1_offset", 66'(offset), 66'd0);
    checkOutput("t1_slip", 66'(slip), 66'd0);

    // 15 invalid headers in window 2 keep lock; 16 in window 3 lose it.
    gen_stream(0, 1'b0);
    mark_invalid(64, 64, 15, dummy);
    mark_invalid(128, 64, 16, last_w3);
    start_run();
    run_to_lock(200, "t4");
    checkOutput("t4_lock_edge", 66'(lock_edge), 66'd65);
    checkOutput("t4_slips", 66'(slips), 66'd0);
    bad = 0;
    while (k < 129) begin
      step();
      if (slip || !block_lock) bad++;
    end
    checkOutput("t4_w2_held", 66'(bad), 66'd0);
    while (k < last_w3 + 1) step();
    checkOutput("t4_pre_loss_lock", 66'(block_lock), 66'd1);
    step();
    checkOutput("t4_loss_lock", 66'(block_lock), 66'd0);
    checkOutput("t4_loss_slip", 66'(slip), 66'd0);
    step();
    checkOutput("t4_slip_pulse", 66'(slip), 66'd1);
    checkOutput("t4_slip_offset", 66'(offset), 66'd1);
    step();
    checkOutput("t4_slip_end", 66'(slip), 66'd0);

    // 64th test of window 2 is also the 16th invalid header.
    gen_stream(0, 1'b0);
    mark_invalid(64, 63, 15, dummy);
    tx_blk[127][1:0] = bad_hdr();
    start_run();
    run_to_lock(200, "t6");
    checkOutput("t6_lock_edge", 66'(lock_edge), 66'd65);
    while (k < 128) step();
    checkOutput("t6_pre_loss_lock", 66'(block_lock), 66'd1);
    step();
    checkOutput("t6_loss_lock", 66'(block_lock), 66'd0);
    step();
    checkOutput("t6_slip_pulse", 66'(slip), 66'd1);
    checkOutput("t6_slip_offset", 66'(offset), 66'd1);

    // Aligned at 0 but the first header is bad: full wrap 65 -> 0.
    gen_stream(0, 1'b0);
    tx_blk[0][1:0] = bad_hdr();
    start_run();
    run_to_lock(3000, "t5");
    checkOutput("t5_slips", 66'(slips), 66'd66);
    checkOutput("t5_max_offset", 66'(max_off), 66'd65);
    checkOutput("t5_offset", 66'(offset), 66'd0);
    checkOutput("t5_lock_edge", 66'(lock_edge), 66'(last_slip_edge + 65));
    for (int i = 0; i < 4; i++) begin
      step();
      checkOutput("t5_block", block_out, tx_blk[12'(k - 2)]);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
